// File: rtl/bpug_seq.sv
// bpug_seq: BPU group layer sequencer (weight/image loads, then CALC0/CALC1/UP steps).
// Define BPUG_SEQ_CSUM_EN to add a 16-bit running sum of forwarded data bytes.
module bpug_seq #(
    parameter int ADDR_W = 12,
    parameter logic [4:0] CALC_OP = 5'h01,
    parameter logic [4:0] NOP_OP = 5'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [3:0]        n_steps,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        data_out,
    output logic [9:0]        instr_out,
    output logic              sel_out,
    output logic              busy,
`ifdef BPUG_SEQ_CSUM_EN
    output logic [15:0]       csum,
`endif
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LD_WGT, LD_IMG0, LD_IMG1, CALC0, CALC1, UP, FIN} state_t;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [3:0] steps_q, step_q, step_d;
    logic [6:0] off_q, off_d;
    logic [9:0] instr_q, instr_d;
    logic rd_q, done_q, accept;
    assign accept = state_q == IDLE && start;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            steps_q <= '0;
            step_q  <= '0;
            off_q   <= '0;
            instr_q <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            step_q  <= step_d;
            instr_q <= instr_d;
            rd_q    <= mem_rd;
            done_q  <= state_q == FIN;
            if (accept) begin
                base_q  <= base_addr;
                steps_q <= n_steps == 4'd0 ? 4'd1 : n_steps;
            end
        end
    end
    always_comb begin
        state_d = state_q;
        off_d   = mem_rd ? off_q + 7'd1 : 7'd0;
        step_d  = state_q == UP ? step_q + 4'd1 : (state_q == IDLE ? 4'd0 : step_q);
        case (state_q)
            IDLE:    state_d = start ? LD_WGT : IDLE;
            LD_WGT:  state_d = off_q == 7'd55 ? LD_IMG0 : LD_WGT;
            LD_IMG0: state_d = off_q == 7'd71 ? LD_IMG1 : LD_IMG0;
            LD_IMG1: state_d = off_q == 7'd87 ? CALC0 : LD_IMG1;
            CALC0:   state_d = CALC1;
            CALC1:   state_d = UP;
            UP:      state_d = step_q + 4'd1 == steps_q ? FIN : CALC0;
            default: state_d = IDLE;
        endcase
    end
    // instr layout: {img_reg_sel, img_reg_up, en{img,wgt}, data_sel, op}
    always_comb begin
        mem_rd = state_q inside {LD_WGT, LD_IMG0, LD_IMG1};
        mem_addr = mem_rd ? base_q + ADDR_W'(off_q) : '0;
        case (state_q)
            LD_WGT:  instr_d = {1'b0, 1'b0, 2'b01, 1'b0, NOP_OP};
            LD_IMG0: instr_d = {1'b0, 1'b0, 2'b10, 1'b0, NOP_OP};
            LD_IMG1: instr_d = {1'b1, 1'b0, 2'b10, 1'b0, NOP_OP};
            CALC0:   instr_d = {1'b0, 1'b0, 2'b00, 1'b0, CALC_OP};
            CALC1:   instr_d = {1'b0, 1'b0, 2'b00, 1'b1, CALC_OP};
            UP:      instr_d = {1'b0, 1'b1, 2'b00, 1'b0, NOP_OP};
            default: instr_d = '0;
        endcase
    end
    assign data_out  = rd_q ? mem_data : 8'h00;
    assign instr_out = instr_q;
    assign sel_out   = rd_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
`ifdef BPUG_SEQ_CSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge clk) begin
        csum_q <= (rst || accept) ? 16'h0000 : csum_q + 16'(data_out);
    end
    assign csum = csum_q;
`endif
endmodule

// File: doc/bpug_seq.md
BPUG_SEQ -- requirements
Module: bpug_seq

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width.
REQ-002 Parameter CALC_OP, default 5'h01, opcode placed in instr_out[4:0] during compute cycles.
REQ-003 Parameter NOP_OP, default 5'h00, opcode placed in instr_out[4:0] in all non-compute cycles.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle pulse; begins a layer sequence.
REQ-007 base_addr  input  ADDR_W  first memory address of the layer block.
REQ-008 n_steps  input  4  number of compute/row-up steps; 0 is treated as 1.
REQ-009 mem_rd  output  1  memory read strobe.
REQ-010 mem_addr  output  ADDR_W  memory read address.
REQ-011 mem_data  input  8  read data, valid exactly 1 cycle after mem_rd.
REQ-012 data_out  output  8  byte stream to the BPU group data_in.
REQ-013 instr_out  output  10  instruction bus to the BPU group: [4:0] op, [5] data_sel, [7:6] en {img,wgt}, [8] img_reg_up, [9] img_reg_sel.
REQ-014 sel_out  output  1  group select; 1 on every load cycle.
REQ-015 busy  output  1  high from the cycle after an accepted start until done.
REQ-016 done  output  1  one-cycle pulse at sequence end.

Function
REQ-017 The FSM SHALL have states IDLE, LD_WGT, LD_IMG0, LD_IMG1, CALC0, CALC1, UP, FIN.
REQ-018 In IDLE, start SHALL latch base_addr and n_steps and move to LD_WGT; start while busy SHALL be ignored.
REQ-019 LD_WGT SHALL issue 56 reads at base_addr+0..55, one per cycle, then go to LD_IMG0.
REQ-020 LD_IMG0 SHALL issue 16 reads at base_addr+56..71, then LD_IMG1 SHALL issue 16 reads at base_addr+72..87, then go to CALC0.
REQ-021 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-022 For each read issued in cycle t, data_out SHALL equal mem_data and instr_out/sel_out SHALL carry the matching load instruction in cycle t+1.
REQ-023 Load instructions: LD_WGT en=01, img_reg_sel=0; LD_IMG0 en=10, img_reg_sel=0; LD_IMG1 en=10, img_reg_sel=1; op=NOP_OP, data_sel=0, up=0.
REQ-024 Each step SHALL be CALC0 (op=CALC_OP, data_sel=0), then CALC1 (op=CALC_OP, data_sel=1), then UP (op=NOP_OP, img_reg_up=1); sel_out=0, en=00, mem_rd=0.
REQ-025 All non-load instructions SHALL also appear on the outputs one cycle after the state issuing them, keeping one uniform pipeline delay.
REQ-026 After the UP of step n_steps, the FSM SHALL enter FIN; otherwise it SHALL return to CALC0.
REQ-027 FIN SHALL last one cycle, drive instr_out=0 and sel_out=0, and return to IDLE. done SHALL pulse in the cycle after FIN.
REQ-028 Total latency from accepted start to done SHALL be 88 + 3*n_steps + 2 cycles.
REQ-029 When no instruction is issued, data_out SHALL be 0, instr_out SHALL be 0, sel_out SHALL be 0 and mem_rd SHALL be 0.

Reset
REQ-030 rst SHALL force IDLE and clear all counters and latched inputs; mem_rd, mem_addr, data_out, instr_out, sel_out, busy and done SHALL read 0 in the cycle after reset is sampled.
REQ-031 rst mid-sequence SHALL abort the sequence with no done pulse, and any read in flight SHALL be discarded.
REQ-032 rst and start asserted together SHALL give rst priority.

Configuration
REQ-033 With BPUG_SEQ_CSUM_EN defined, the block SHALL add output csum (16 bits): the mod-2^16 sum of all bytes forwarded on data_out in the current sequence.
REQ-034 csum SHALL clear on reset and on accepted start, and SHALL be stable when done pulses.
REQ-035 Without BPUG_SEQ_CSUM_EN, the csum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 The bench SHALL cover: base_addr=0x100, n_steps=1, memory byte=addr[7:0] -> 56 outputs with en=01 carrying 0x00..0x37, then 32 outputs with en=10 (img_reg_sel 0 then 1) carrying 0x38..0x57, then one CALC/CALC/UP triple; done 93 cycles after start.
REQ-037 The bench SHALL cover: n_steps=0 -> identical to n_steps=1.
REQ-038 The bench SHALL cover: n_steps=15 -> 15 triples, each with data_sel 0 then 1, followed by img_reg_up=1; done at cycle 135.
REQ-039 The bench SHALL cover: base_addr=0xFFF0 with ADDR_W=16 -> mem_addr wraps 0xFFFF to 0x0000 at read 16.
REQ-040 The bench SHALL cover: rst at cycle 40 -> all outputs 0 next cycle, no done; a second start 5 cycles later completes normally; start pulsed while busy has no effect.
REQ-041 The bench SHALL cover: with BPUG_SEQ_CSUM_EN and all bytes 0xFF -> csum=0x57A8 (88*255) at done.
